// File: rtl/aes_dec_round_sched.sv
// aes_dec_round_sched: iterative AES-256 decryption round scheduler.
// It performs the initial AddRoundKey with rk[NR], then launches the shared
// inverse-round datapath once per round while stepping the round-key index
// from NR-1 down to 0. On the final round it tells the datapath to skip
// InvMixColumns. When the last round completes it registers the plaintext
// and emits a one-cycle out_ready pulse.
// Optional feature macro: AES_DEC_WATCHDOG_EN. When it is defined, a stalled
// datapath aborts the block with a one-cycle err pulse.
module aes_dec_round_sched #(
    parameter int NR       = 14,
    parameter int KIDX_W   = 4,
    parameter int WD_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      in_data,
    input  logic              in_ready,
    output logic              busy,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
    output logic [127:0]      rnd_data,
    output logic              rnd_ready,
    output logic              rnd_last,
    input  logic [127:0]      rnd_result,
    input  logic              rnd_done,
    output logic [127:0]      out_data,
    output logic              out_ready,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} fsm_t;

    localparam logic [KIDX_W-1:0] LP_K_NR  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] LP_K_NR1 = KIDX_W'(NR - 1);

    fsm_t              r_fsm, w_fsm_nxt;
    logic [127:0]      r_state;
    logic [KIDX_W-1:0] r_round;
    logic [KIDX_W-1:0] r_rk_idx;
    logic [127:0]      r_out_data;
    logic              r_out_ready;
    logic              r_err;

    logic w_accept, w_step, w_last, w_abort;
    logic w_busy, w_rnd_ready, w_rnd_last;

    assign w_accept = (r_fsm == S_IDLE) && in_ready;
    assign w_step   = (r_fsm == S_WAIT) && rnd_done;
    assign w_last   = (r_round == '0);

`ifdef AES_DEC_WATCHDOG_EN
    logic [4:0] r_wd;

    // Counts WAIT cycles without rnd_done; cleared on each launch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wd <= '0;
        else if (r_fsm == S_LAUNCH)
            r_wd <= '0;
        else if (r_fsm == S_WAIT && !rnd_done)
            r_wd <= r_wd + 5'd1;
    end

    // The abort fires on the WD_LIMIT-th stalled WAIT cycle.
    assign w_abort = (r_fsm == S_WAIT) && !rnd_done && (r_wd == 5'(WD_LIMIT - 1));
`else
    logic [4:0] w_unused_wd;
    assign w_unused_wd = 5'(WD_LIMIT);
    assign w_abort     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_fsm <= S_IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_busy      = 1'b1;
        w_rnd_ready = 1'b0;
        w_rnd_last  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_busy = 1'b0;
                if (in_ready)
                    w_fsm_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_rnd_ready = 1'b1;
                w_rnd_last  = w_last;
                w_fsm_nxt   = S_WAIT;
            end
            S_WAIT: begin
                w_rnd_last = w_last;
                if (rnd_done)
                    w_fsm_nxt = w_last ? S_DONE : S_LAUNCH;
                else if (w_abort)
                    w_fsm_nxt = S_IDLE;
            end
            S_DONE: begin
                w_fsm_nxt = S_IDLE;
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    // Block state, round counter, key index and registered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= '0;
            r_round     <= LP_K_NR1;
            r_rk_idx    <= LP_K_NR;
            r_out_data  <= '0;
            r_out_ready <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // The pulses are registered so they line up with the DONE / IDLE cycle.
            r_out_ready <= w_step && w_last;
            r_err       <= w_abort;
            if (w_accept) begin
                // Initial AddRoundKey uses rk[NR], which is presented while idle.
                r_state  <= in_data ^ rk_data;
                r_round  <= LP_K_NR1;
                r_rk_idx <= LP_K_NR1;
            end
            if (w_step) begin
                r_state <= rnd_result;
                if (w_last) begin
                    // Plaintext is loaded on entry to DONE so that it is valid
                    // in the same cycle as the out_ready pulse.
                    r_out_data <= rnd_result;
                end else begin
                    r_round  <= r_round - 1'b1;
                    r_rk_idx <= r_round - 1'b1;
                end
            end
            if (r_fsm == S_DONE || w_abort)
                r_rk_idx <= LP_K_NR;
        end
    end

    assign busy      = w_busy;
    assign rk_idx    = r_rk_idx;
    assign rnd_data  = r_state;
    assign rnd_ready = w_rnd_ready;
    assign rnd_last  = w_rnd_last;
    assign out_data  = r_out_data;
    assign out_ready = r_out_ready;
    assign err       = r_err;

endmodule

// File: tb/tb_aes_dec_round_sched.sv
// Bench for aes_dec_round_sched. The key store and an AES inverse-round
// datapath with configurable latency are modelled here. Expected plaintexts
// come from FIPS-197 constants or from a whole-block reference decryption.
module tb_aes_dec_round_sched;

    localparam logic [127:0] CT1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY1 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready = 1'b0;
    logic         busy;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] rnd_data;
    logic         rnd_ready;
    logic         rnd_last;
    logic [127:0] rnd_result;
    logic         rnd_done;
    logic [127:0] out_data;
    logic         out_ready;
    logic         err;

    aes_dec_round_sched dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .rk_idx(rk_idx), .rk_data(rk_data), .rnd_data(rnd_data),
        .rnd_ready(rnd_ready), .rnd_last(rnd_last), .rnd_result(rnd_result),
        .rnd_done(rnd_done), .out_data(out_data), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   sbox [256];
    logic [7:0]   isbox[256];
    logic [127:0] rk   [15];

    assign rk_data = rk[rk_idx];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (unless last).
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            b[4*(((i/4) + (i%4)) % 4) + (i%4)] = isbox[gb(s, i)];
        for (int i = 0; i < 16; i++)
            b[i] ^= gb(k, i);
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                b[4*c]   = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
                b[4*c+1] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
                b[4*c+2] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
                b[4*c+3] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[14];
        for (int r = 13; r >= 1; r--)
            s = inv_round(s, rk[r], 1'b0);
        return inv_round(s, rk[0], 1'b1);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gm(inv, 8'(x));
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic key_expand(input logic [255:0] key);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Datapath model: result of the launched round appears lat_L cycles after rnd_ready.
    int           lat_L = 1;
    logic         dp_pend = 1'b0;
    int           dp_due = 0;
    logic [127:0] dp_res = '0;
    logic         hold = 1'b0;
    logic         stray = 1'b0;
    logic [127:0] stray_val = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_pend <= 1'b0;
        end else if (rnd_ready) begin
            dp_pend <= 1'b1;
            dp_due  <= cyc + lat_L;
            dp_res  <= inv_round(rnd_data, rk_data, rnd_last);
        end else if (dp_pend && cyc == dp_due) begin
            dp_pend <= 1'b0;
        end
    end

    assign rnd_done   = (dp_pend && cyc == dp_due && !hold) || stray;
    assign rnd_result = stray ? stray_val : dp_res;

    logic [3:0] rkq[$];
    logic       lastq[$];
    logic [3:0] acc_idx;
    int         busy_after;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input logic [127:0] ct, input int L, input bit inject_ir,
                       input bit stray_launch, output logic [127:0] pt, output int lat,
                       output int nrdy);
        int c0;
        lat = -1; nrdy = 0; pt = '0; busy_after = -1;
        lat_L = L;
        rkq.delete(); lastq.delete();
        @(negedge clk);
        chk("idle_before_accept", 128'(busy), 128'(0));
        in_data = ct; in_ready = 1'b1; c0 = cyc; acc_idx = rk_idx;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            in_ready = 1'b0; stray = 1'b0;
            if (inject_ir && cyc - c0 == 10) begin
                chk("busy_at_2nd_in_ready", 128'(busy), 128'(1));
                in_data = ~ct; in_ready = 1'b1;
            end
            if (rnd_ready) begin
                rkq.push_back(rk_idx);
                lastq.push_back(rnd_last);
                if (stray_launch) begin stray = 1'b1; stray_val = rnd128(); end
            end
            if (lat >= 0 && cyc - c0 == lat + 1) busy_after = int'(busy);
            if (out_ready) begin
                nrdy++;
                if (lat < 0) begin lat = cyc - c0; pt = out_data; end
            end
            if (lat >= 0 && cyc - c0 >= lat + 3) break;
        end
        in_ready = 1'b0; stray = 1'b0;
    endtask

    initial begin
        logic [127:0] pt, exp, prev;
        int lat, nrdy, L, found, nl, l3, ecnt, ecyc, ordy;

        build_tables();
        key_expand(KEY1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(14));
        chk("rst_rnd_ready", 128'(rnd_ready), 128'(0));
        chk("rst_rnd_last", 128'(rnd_last), 128'(0));
        chk("rst_out_ready", 128'(out_ready), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_rnd_data", rnd_data, 128'(0));
        reset = 1'b1;

        // Stray rnd_done while idle
        @(negedge clk); stray = 1'b1; stray_val = rnd128();
        @(negedge clk); stray = 1'b0;
        chk("stray_idle_busy", 128'(busy), 128'(0));
        chk("stray_idle_rnd_data", rnd_data, 128'(0));
        chk("stray_idle_out_ready", 128'(out_ready), 128'(0));

        // FIPS-197 vector, L=1, with key-index and last-round monitoring
        run(CT1, 1, 1'b0, 1'b0, pt, lat, nrdy);
        chk("t1_plaintext", pt, PT1);
        chk("t1_latency", 128'(lat), 128'(29));
        chk("t1_nready", 128'(nrdy), 128'(1));
        chk("t1_busy_after", 128'(busy_after), 128'(0));
        chk("t2_ark_idx", 128'(acc_idx), 128'(14));
        chk("t2_npulses", 128'(rkq.size()), 128'(14));
        for (int i = 0; i < 14 && i < rkq.size(); i++) begin
            chk($sformatf("t2_rk_idx_%0d", i), 128'(rkq[i]), 128'(13 - i));
            chk($sformatf("t2_last_%0d", i), 128'(lastq[i]), 128'(i == 13));
        end

        // Second in_ready mid-block is ignored
        run(CT1, 1, 1'b1, 1'b0, pt, lat, nrdy);
        chk("t3_plaintext", pt, PT1);
        chk("t3_latency", 128'(lat), 128'(29));
        chk("t3_nready", 128'(nrdy), 128'(1));

        // Reset in WAIT of the round using rk_idx=7
        @(negedge clk);
        in_data = CT1; in_ready = 1'b1; lat_L = 1; found = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); in_ready = 1'b0;
            if (rnd_ready && rk_idx == 4'd7) begin found = 1; break; end
        end
        chk("t4_found_round7", 128'(found), 128'(1));
        @(negedge clk);
        chk("t4_in_wait_idx", 128'(rk_idx), 128'(7));
        reset = 1'b0;
        @(negedge clk);
        chk("t4_busy", 128'(busy), 128'(0));
        chk("t4_rk_idx", 128'(rk_idx), 128'(14));
        chk("t4_rnd_ready", 128'(rnd_ready), 128'(0));
        chk("t4_rnd_last", 128'(rnd_last), 128'(0));
        chk("t4_out_ready", 128'(out_ready), 128'(0));
        chk("t4_out_data", out_data, 128'(0));
        chk("t4_rnd_data", rnd_data, 128'(0));
        reset = 1'b1;
        run(CT1, 1, 1'b0, 1'b0, pt, lat, nrdy);
        chk("t4_rerun_plaintext", pt, PT1);
        chk("t4_rerun_latency", 128'(lat), 128'(29));

        // Stray rnd_done in LAUNCH cycles, datapath latency 4
        run(CT1, 4, 1'b0, 1'b1, pt, lat, nrdy);
        chk("t5_plaintext", pt, PT1);
        chk("t5_latency", 128'(lat), 128'(71));
        chk("t5_nready", 128'(nrdy), 128'(1));

        // Random blocks and keys against the reference decryption
        for (int k = 0; k < 6; k++) begin
            logic [127:0] ct;
            if (k >= 3) key_expand({rnd128(), rnd128()});
            ct = rnd128();
            L = $urandom_range(1, 4);
            exp = ref_dec(ct);
            run(ct, L, 1'b0, (k % 2 == 1), pt, lat, nrdy);
            chk($sformatf("rand%0d_plaintext", k), pt, exp);
            chk($sformatf("rand%0d_latency", k), 128'(lat), 128'(14 * (L + 1) + 1));
            chk($sformatf("rand%0d_busy_after", k), 128'(busy_after), 128'(0));
        end
        key_expand(KEY1);

        // Datapath stalls after the third launch
        prev = out_data; lat_L = 1;
        @(negedge clk);
        in_data = CT1; in_ready = 1'b1;
        nl = 0; l3 = -1; ecnt = 0; ecyc = -1; ordy = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk); in_ready = 1'b0;
            if (rnd_ready) begin
                nl++;
                if (nl == 3) begin hold = 1'b1; l3 = cyc; end
            end
            if (err) begin ecnt++; ecyc = cyc; end
            if (out_ready) ordy++;
        end
        chk("t6_launches", 128'(nl), 128'(3));
        chk("t6_no_out_ready", 128'(ordy), 128'(0));
`ifdef AES_DEC_WATCHDOG_EN
        chk("t6_err_count", 128'(ecnt), 128'(1));
        chk("t6_err_cycle", 128'(ecyc - l3), 128'(16));
        chk("t6_busy_end", 128'(busy), 128'(0));
        chk("t6_out_data_kept", out_data, prev);
`else
        chk("t6_err_count", 128'(ecnt), 128'(0));
        chk("t6_busy_end", 128'(busy), 128'(1));
`endif
        hold = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_recover_busy", 128'(busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
